// File: rtl/lm_sm_sequencer.sv
// Expands one LM/SM instruction into a run of single-register memory micro-ops,
// lowest selected register first, while holding fetch.
module lm_sm_sequencer #(
    parameter int DATA_W    = 16,
    parameter int NREG      = 8,
    parameter int ADDR_STEP = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_is_lm,
    input  logic              in_is_sm,
    input  logic [2:0]        in_base,
    input  logic [NREG-1:0]   in_mask,
    input  logic              pipe_hold,
    input  logic              ex_flush,
    output logic              stall_fetch,
    output logic              uop_valid,
    output logic              uop_load,
    output logic              uop_store,
    output logic [2:0]        uop_base,
    output logic [2:0]        uop_reg,
    output logic [DATA_W-1:0] uop_offset,
    output logic              busy,
    output logic              done
);

    typedef enum logic {IDLE, SEQ} state_t;

    state_t            state_reg, state_next;
    logic [NREG-1:0]   mask_reg, mask_next;
    logic [2:0]        base_reg, base_next;
    logic              load_reg, load_next;
    logic              store_reg, store_next;
    logic [DATA_W-1:0] offset_reg, offset_next;
    logic              zero_done_reg, zero_done_next;

    logic              accept;
    logic [NREG-1:0]   rem_mask;
    logic [2:0]        cur_idx;

    // Lowest set bit of the pending mask is the register issued this cycle.
    always_comb begin
        cur_idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (mask_reg[i]) cur_idx = 3'(i);
        end
    end

    // Pending mask with the current (lowest) bit removed.
    assign rem_mask = mask_reg & (mask_reg - NREG'(1));

    assign accept = (state_reg == IDLE) && in_valid && (in_is_lm || in_is_sm) && !ex_flush;

    always_comb begin
        state_next     = state_reg;
        mask_next      = mask_reg;
        base_next      = base_reg;
        load_next      = load_reg;
        store_next     = store_reg;
        offset_next    = offset_reg;
        zero_done_next = 1'b0;
        stall_fetch    = 1'b0;
        done           = 1'b0;

        if (ex_flush) begin
            state_next  = IDLE;
            mask_next   = '0;
            base_next   = '0;
            load_next   = 1'b0;
            store_next  = 1'b0;
            offset_next = '0;
        end else if (state_reg == IDLE) begin
            done = zero_done_reg;
            if (accept) begin
                if (in_mask == '0) begin
                    zero_done_next = 1'b1;
                end else begin
                    stall_fetch = 1'b1;
                    state_next  = SEQ;
                    mask_next   = in_mask;
                    base_next   = in_base;
                    load_next   = in_is_lm;
                    store_next  = in_is_sm;
                    offset_next = '0;
                end
            end
        end else begin
            stall_fetch = pipe_hold || (rem_mask != '0);
            if (!pipe_hold) begin
                mask_next   = rem_mask;
                offset_next = offset_reg + DATA_W'(ADDR_STEP);
                if (rem_mask == '0) begin
                    // Last register accepted: drop back to IDLE with clean outputs.
                    done        = 1'b1;
                    state_next  = IDLE;
                    base_next   = '0;
                    load_next   = 1'b0;
                    store_next  = 1'b0;
                    offset_next = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            mask_reg      <= '0;
            base_reg      <= '0;
            load_reg      <= 1'b0;
            store_reg     <= 1'b0;
            offset_reg    <= '0;
            zero_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mask_reg      <= mask_next;
            base_reg      <= base_next;
            load_reg      <= load_next;
            store_reg     <= store_next;
            offset_reg    <= offset_next;
            zero_done_reg <= zero_done_next;
        end
    end

    assign busy       = (state_reg == SEQ);
    assign uop_valid  = (state_reg == SEQ);
    assign uop_load   = load_reg;
    assign uop_store  = store_reg;
    assign uop_base   = base_reg;
    assign uop_reg    = (state_reg == SEQ) ? cur_idx : 3'd0;
    assign uop_offset = offset_reg;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed and random stimulus for lm_sm_sequencer, checked cycle by cycle against
// a queue-based model of the instruction-level micro-op sequence.
module tb_lm_sm_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_is_lm, in_is_sm;
    logic [2:0]  in_base;
    logic [7:0]  in_mask;
    logic        pipe_hold, ex_flush;
    logic        stall_fetch, uop_valid, uop_load, uop_store, busy, done;
    logic [2:0]  uop_base, uop_reg;
    logic [15:0] uop_offset;

    int errors = 0;
    int checks = 0;

    // Model: registers still to be issued for the current instruction, in order.
    int          m_regs[$];
    int          m_k = 0;
    logic        m_lm = 1'b0, m_sm = 1'b0;
    logic [2:0]  m_base = '0;
    logic        m_zero_pend = 1'b0;

    lm_sm_sequencer #(.DATA_W(16), .NREG(8), .ADDR_STEP(2)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_is_lm(in_is_lm), .in_is_sm(in_is_sm),
        .in_base(in_base), .in_mask(in_mask),
        .pipe_hold(pipe_hold), .ex_flush(ex_flush),
        .stall_fetch(stall_fetch), .uop_valid(uop_valid),
        .uop_load(uop_load), .uop_store(uop_store),
        .uop_base(uop_base), .uop_reg(uop_reg), .uop_offset(uop_offset),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
    task automatic step(input logic v, input logic lm, input logic sm, input logic [2:0] b,
                        input logic [7:0] m, input logic h, input logic f, input logic r);
        logic        inseq;
        logic        exp_done, exp_stall, acc;
        logic [15:0] exp_off;
        @(posedge clk);
        #1;
        in_valid = v; in_is_lm = lm; in_is_sm = sm; in_base = b;
        in_mask = m; pipe_hold = h; ex_flush = f; reset = r;
        #4;
        inseq = (m_regs.size() > 0);
        acc   = !inseq && v && (lm || sm) && !f;
        if (!r) begin
            exp_off   = 16'(2 * m_k);
            exp_done  = !f && ((inseq && !h && m_regs.size() == 1) || (!inseq && m_zero_pend));
            exp_stall = inseq ? (h || m_regs.size() > 1) : (acc && m != 8'h00);
            chk("uop_valid", 32'(uop_valid), 32'(inseq));
            chk("busy", 32'(busy), 32'(inseq));
            chk("done", 32'(done), 32'(exp_done));
            if (!f) chk("stall_fetch", 32'(stall_fetch), 32'(exp_stall));
            if (inseq) begin
                chk("uop_reg", 32'(uop_reg), 32'(m_regs[0]));
                chk("uop_offset", 32'(uop_offset), 32'(exp_off));
                chk("uop_load", 32'(uop_load), 32'(m_lm));
                chk("uop_store", 32'(uop_store), 32'(m_sm));
                chk("uop_base", 32'(uop_base), 32'(m_base));
            end
        end
        if (r || f) begin
            m_regs.delete(); m_k = 0; m_zero_pend = 1'b0;
        end else if (inseq) begin
            if (!h) begin
                void'(m_regs.pop_front());
                m_k++;
            end
        end else begin
            m_zero_pend = acc && (m == 8'h00);
            if (acc) begin
                $display("accept %s base=R%0d mask=%08b", lm ? "LM" : "SM", b, m);
                if (m != 8'h00) begin
                    for (int i = 0; i < 8; i++) if (m[i]) m_regs.push_back(i);
                    m_k = 0; m_lm = lm; m_sm = sm; m_base = b;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 3'd0, 8'h00, 0, 0, 0);
    endtask

    initial begin
        in_valid = 0; in_is_lm = 0; in_is_sm = 0; in_base = 0; in_mask = 0;
        pipe_hold = 0; ex_flush = 0; reset = 1;
        step(0, 0, 0, 3'd0, 8'h00, 0, 0, 1);
        step(0, 0, 0, 3'd0, 8'h00, 0, 0, 1);
        // Reset state.
        @(negedge clk);
        chk("rst_uop_valid", 32'(uop_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_offset", 32'(uop_offset), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // LM R1 mask 0000_0101.
        step(1, 1, 0, 3'd1, 8'b0000_0101, 0, 0, 0);
        idle(4);
        // SM mask FF.
        step(1, 0, 1, 3'd3, 8'hFF, 0, 0, 0);
        idle(10);
        // LM mask 1000_0010 with hold on the first uop.
        step(1, 1, 0, 3'd2, 8'b1000_0010, 0, 0, 0);
        step(0, 0, 0, 3'd0, 8'h00, 1, 0, 0);
        step(1, 1, 0, 3'd5, 8'h0F, 1, 0, 0);
        step(0, 0, 0, 3'd0, 8'h00, 1, 0, 0);
        idle(3);
        // SM mask 0F flushed on the second uop, then a normal LM.
        step(1, 0, 1, 3'd4, 8'h0F, 0, 0, 0);
        step(0, 0, 0, 3'd0, 8'h00, 0, 0, 0);
        step(0, 0, 0, 3'd0, 8'h00, 0, 1, 0);
        step(0, 0, 0, 3'd0, 8'h00, 0, 0, 0);
        step(1, 1, 0, 3'd6, 8'b0000_0110, 0, 0, 0);
        idle(4);
        // Flush coinciding with an accept: nothing latched.
        step(1, 1, 0, 3'd6, 8'h11, 0, 1, 0);
        idle(2);
        // LM mask 00.
        step(1, 1, 0, 3'd7, 8'h00, 0, 0, 0);
        idle(3);
        // Reset mid-sequence, then a fresh LM.
        step(1, 1, 0, 3'd2, 8'hFF, 0, 0, 0);
        idle(3);
        step(0, 0, 0, 3'd0, 8'h00, 0, 0, 1);
        step(0, 0, 0, 3'd0, 8'h00, 0, 0, 0);
        step(1, 1, 0, 3'd3, 8'b0000_0101, 0, 0, 0);
        idle(4);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            logic       v, lm, h, f, r;
            logic [7:0] m;
            int         sel;
            v   = ($urandom_range(0, 2) != 0);
            lm  = $urandom_range(0, 1);
            sel = $urandom_range(0, 9);
            m   = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
            h   = ($urandom_range(0, 3) == 0);
            f   = ($urandom_range(0, 19) == 0);
            r   = ($urandom_range(0, 79) == 0);
            step(v && ($urandom_range(0, 4) != 0), lm, !lm, 3'($urandom), m, h, f, r);
        end
        idle(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
